// File: rtl/serial_add_sub_pkg.sv
// Shared types, constants and helpers for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed saturation value for an nbit-wide result.
  // sign=0 gives the largest positive value; sign=1 gives the most negative value.
  // Only the low nbit bits are meaningful.
  function automatic logic [63:0] sat_value(input logic sign, input int unsigned nbit);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i + 1 < nbit) begin
        v[i] = ~sign;
      end else if (i + 1 == nbit) begin
        v[i] = sign;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder shared by every bit of a serial operation.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single full adder.
// Results, carry and overflow are published only when an operation completes.
// Optional macro SERIAL_ADD_SUB_SAT_EN saturates the result on signed overflow.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned NBIT = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            sub_i,
  input  logic [NBIT-1:0] operand_a_i,
  input  logic [NBIT-1:0] operand_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [NBIT-1:0] result_o,
  output logic            carry_o,
  output logic            overflow_o
);

  localparam int unsigned CNT_W = $clog2(NBIT + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NBIT - 1);

  state_e            state_q;
  logic [NBIT-1:0]   a_q;
  logic [NBIT-1:0]   b_q;
  logic              c_q;
  logic [CNT_W-1:0]  cnt_q;
  // Holds the NBIT-1 sum bits produced so far; the last bit joins it at completion.
  logic [NBIT-2:0]   acc_q;
  logic [NBIT-2:0]   acc_d;
  logic [NBIT-1:0]   res_d;
  logic [NBIT-1:0]   result_q;
  logic              carry_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;
`ifdef SERIAL_ADD_SUB_SAT_EN
  logic              sign_a_q;
  logic [63:0]       sat_full;
`endif

  logic sum_bit;
  logic carry_out;

  full_adder_cell u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (c_q),
    .s_o (sum_bit),
    .c_o (carry_out)
  );

  // Next partial accumulator and the completed result (optionally saturated).
  always_comb begin
    acc_d = {sum_bit, acc_q[NBIT-2:1]};
    res_d = {sum_bit, acc_q};
`ifdef SERIAL_ADD_SUB_SAT_EN
    sat_full = sat_value(sign_a_q, NBIT);
    if (c_q ^ carry_out) begin
      res_d = sat_full[NBIT-1:0];
    end
`endif
  end

  // Sequencer: latch operands, shift one bit per cycle, publish flags at the last bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_SAT_EN
      sign_a_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= operand_a_i;
            // Subtract as a + ~b + 1: invert b here, seed the carry with 1.
            b_q     <= (sub_i == OP_SUB) ? ~operand_b_i : operand_b_i;
            c_q     <= sub_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef SERIAL_ADD_SUB_SAT_EN
            sign_a_q <= operand_a_i[NBIT-1];
`endif
          end
        end
        StRun: begin
          a_q   <= {1'b0, a_q[NBIT-1:1]};
          b_q   <= {1'b0, b_q[NBIT-1:1]};
          c_q   <= carry_out;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            result_q <= res_d;
            carry_q  <= carry_out;
            // Carry into the MSB differing from carry out of it means signed overflow.
            ovf_q    <= c_q ^ carry_out;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed cases plus random operands
// against an integer-arithmetic reference model.
module tb_serial_add_sub;

  localparam int unsigned NBIT = 10;
  localparam int MOD  = 1 << NBIT;
  localparam int SMAX = (1 << (NBIT - 1)) - 1;
  localparam int SMIN = -(1 << (NBIT - 1));

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            start_i;
  logic            sub_i;
  logic [NBIT-1:0] operand_a_i;
  logic [NBIT-1:0] operand_b_i;
  logic            busy_o;
  logic            done_o;
  logic [NBIT-1:0] result_o;
  logic            carry_o;
  logic            overflow_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [NBIT-1:0] prev_res   = '0;
  logic            prev_carry = 1'b0;
  logic            prev_ovf   = 1'b0;

  serial_add_sub #(.NBIT(NBIT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .sub_i       (sub_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .carry_o     (carry_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic sub,
                       output logic [NBIT-1:0] res, output logic carry, output logic ovf);
    int ua, ub, sa, sb, sr, u;
    ua = int'(a);
    ub = int'(b);
    sa = a[NBIT-1] ? ua - MOD : ua;
    sb = b[NBIT-1] ? ub - MOD : ub;
    sr = sub ? sa - sb : sa + sb;
    ovf = (sr > SMAX) || (sr < SMIN);
    carry = sub ? (ua >= ub) : (ua + ub >= MOD);
    u = sub ? ua - ub + MOD : ua + ub;
    res = NBIT'(u % MOD);
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (ovf) res = (sr > SMAX) ? NBIT'(SMAX) : NBIT'(SMIN + MOD);
`endif
  endtask

  // One operation; optionally pulse start again mid-run with different operands.
  task automatic run_op(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic sub,
                        input bit glitch, input string tag);
    logic [NBIT-1:0] er;
    logic ec, eo;
    int n;
    model(a, b, sub, er, ec, eo);
    @(negedge clk_i);
    start_i = 1'b1; operand_a_i = a; operand_b_i = b; sub_i = sub;
    @(posedge clk_i); #1;
    check({tag, "_busy_start"}, 64'(busy_o), 64'd1);
    n = 1;
    while (!done_o && n <= int'(NBIT) + 5) begin
      if (n == 1) begin
        @(negedge clk_i);
        start_i = 1'b0;
      end
      if (n == 3) begin
        check({tag, "_res_held"}, 64'(result_o), 64'(prev_res));
        check({tag, "_busy_mid"}, 64'(busy_o), 64'd1);
      end
      if (glitch && n == 3) begin
        @(negedge clk_i);
        start_i = 1'b1; operand_a_i = ~a; operand_b_i = ~b; sub_i = ~sub;
      end else if (glitch && n == 4) begin
        @(negedge clk_i);
        start_i = 1'b0;
      end
      @(posedge clk_i); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NBIT + 1));
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_busy_done"}, 64'(busy_o), 64'd0);
    check({tag, "_result"}, 64'(result_o), 64'(er));
    check({tag, "_carry"}, 64'(carry_o), 64'(ec));
    check({tag, "_ovf"}, 64'(overflow_o), 64'(eo));
    @(posedge clk_i); #1;
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    prev_res = er; prev_carry = ec; prev_ovf = eo;
  endtask

  initial begin
    logic [NBIT-1:0] er;
    logic ec, eo;
    int cyc, t1, t2;

    rst_ni = 1'b0; start_i = 1'b0; sub_i = 1'b0; operand_a_i = '0; operand_b_i = '0;
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_carry", 64'(carry_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(10'd5, 10'd3, 1'b0, 1'b0, "add");
    run_op(10'd5, 10'd3, 1'b1, 1'b0, "sub");
    run_op(10'd3, 10'd5, 1'b1, 1'b0, "neg");
    run_op(10'h1FF, 10'd1, 1'b0, 1'b0, "povf");
    run_op(10'h200, 10'd1, 1'b1, 1'b0, "novf");
    run_op(10'd77, 10'd0, 1'b1, 1'b0, "subz");
    run_op(10'h3FF, 10'h3FF, 1'b0, 1'b0, "allones");
    run_op(10'd100, 10'd23, 1'b0, 1'b1, "glitch");

    // start held high: results back to back, done pulses NBIT+2 apart.
    model(10'd5, 10'd3, 1'b0, er, ec, eo);
    @(negedge clk_i);
    start_i = 1'b1; operand_a_i = 10'd5; operand_b_i = 10'd3; sub_i = 1'b0;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
      if (done_o) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    @(negedge clk_i);
    start_i = 1'b0;
    check("b2b_spacing", 64'(t2 - t1), 64'(NBIT + 2));
    check("b2b_first", 64'(t1), 64'(NBIT + 1));
    check("b2b_result", 64'(result_o), 64'(er));
    prev_res = er; prev_carry = ec; prev_ovf = eo;
    repeat (3) @(posedge clk_i);

    // Reset mid-operation: outputs clear immediately, then a normal op completes.
    run_op(10'h1FF, 10'd1, 1'b0, 1'b0, "pre_rst");
    @(negedge clk_i);
    start_i = 1'b1; operand_a_i = 10'd9; operand_b_i = 10'd4; sub_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_done", 64'(done_o), 64'd0);
    check("mrst_result", 64'(result_o), 64'd0);
    check("mrst_carry", 64'(carry_o), 64'd0);
    check("mrst_ovf", 64'(overflow_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    prev_res = '0; prev_carry = 1'b0; prev_ovf = 1'b0;
    run_op(10'd9, 10'd4, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      run_op(NBIT'($urandom), NBIT'($urandom), 1'($urandom), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
